// File: rtl/cls_axil_reg_slave.sv
// rtl/cls_axil_reg_slave.sv - AXI4-Lite register bank for the cross-layer switch control port
//
// Purpose: slave end of the S00_AXI control interface. Holds NUM_REGS 32-bit
// control words, exports them flat to the switch datapath and pulses a
// per-register strobe the cycle after each committed write.
//
// Ports:
//   s00_axi_aclk / s00_axi_aresetn   clock, asynchronous active-low reset
//   s00_axi_aw* / s00_axi_w*          write address / data channels (AW and W independent)
//   s00_axi_b*                        write response channel
//   s00_axi_ar* / s00_axi_r*          read address / data channels
//   reg_q                             register contents, reg i at [32i+31:32i]
//   reg_wr_pulse                      one-cycle pulse per register after a commit
//
// Build option: define CLS_AXIL_ERR_RESP_EN to answer out-of-range accesses
// with SLVERR; otherwise they complete with OKAY (writes dropped, reads 0).

module cls_axil_reg_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                              s00_axi_aclk,
  input  logic                              s00_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                        s00_axi_awprot,
  input  logic                              s00_axi_awvalid,
  output logic                              s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                              s00_axi_wvalid,
  output logic                              s00_axi_wready,
  output logic [1:0]                        s00_axi_bresp,
  output logic                              s00_axi_bvalid,
  input  logic                              s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                        s00_axi_arprot,
  input  logic                              s00_axi_arvalid,
  output logic                              s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                        s00_axi_rresp,
  output logic                              s00_axi_rvalid,
  input  logic                              s00_axi_rready,
  output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]               reg_wr_pulse
);

  localparam int DW     = C_S_AXI_DATA_WIDTH;
  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef CLS_AXIL_ERR_RESP_EN
  localparam logic [1:0] RESP_OOR  = 2'b10;
`else
  localparam logic [1:0] RESP_OOR  = 2'b00;
`endif

  // Write channel state
  logic              aw_held_q, aw_held_d;
  logic              w_held_q, w_held_d;
  logic [IDX_W-1:0]  aw_idx_q, aw_idx_d;
  logic [DW-1:0]     w_data_q, w_data_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;

  // Read channel state
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  // Register bank
  logic [DW-1:0]       regs_q [NUM_REGS];
  logic [DW-1:0]       regs_d [NUM_REGS];
  logic [NUM_REGS-1:0] pulse_q, pulse_d;

  // Combinational helpers
  logic              aw_hs, w_hs, ar_hs, commit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;
  logic [DW-1:0]     wr_data, rd_word;
  logic [STRB_W-1:0] wr_strb;
  logic              wr_in_range, rd_in_range;

  // Protection bits and byte-offset address bits carry no meaning here.
  logic unused_sigs;
  assign unused_sigs = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  always_comb begin
    aw_hs = s00_axi_awvalid && awready_q;
    w_hs  = s00_axi_wvalid && wready_q;
    ar_hs = s00_axi_arvalid && arready_q;

    // A channel counts as present if it was captured earlier or handshakes now.
    commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    wr_idx  = aw_held_q ? aw_idx_q : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    wr_data = w_held_q  ? w_data_q : s00_axi_wdata;
    wr_strb = w_held_q  ? w_strb_q : s00_axi_wstrb;
    wr_in_range = 32'(wr_idx) < 32'(NUM_REGS);

    rd_idx = s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
    rd_in_range = 32'(rd_idx) < 32'(NUM_REGS);
    // Reads sample the pre-commit bank, so a same-edge write is not visible.
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (32'(rd_idx) == 32'(i)) rd_word = regs_q[i];
    end

    aw_held_d = aw_held_q;
    w_held_d  = w_held_q;
    aw_idx_d  = aw_idx_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pulse_d   = '0;
    regs_d    = regs_q;

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_idx_d  = s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end
    if (bvalid_q && s00_axi_bready) bvalid_d = 1'b0;

    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = wr_in_range ? RESP_OKAY : RESP_OOR;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_in_range && (32'(wr_idx) == 32'(i))) begin
          pulse_d[i] = 1'b1;
          for (int b = 0; b < STRB_W; b++) begin
            if (wr_strb[b]) regs_d[i][8*b +: 8] = wr_data[8*b +: 8];
          end
        end
      end
    end

    if (rvalid_q && s00_axi_rready) rvalid_d = 1'b0;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_in_range ? rd_word : '0;
      rresp_d  = rd_in_range ? RESP_OKAY : RESP_OOR;
    end

    // Readies are registered from next state, giving at most one
    // transaction per two cycles on each path.
    awready_d = !aw_held_d && !bvalid_d;
    wready_d  = !w_held_d && !bvalid_d;
    arready_d = !rvalid_d;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      aw_held_q <= 1'b0;
      w_held_q  <= 1'b0;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q  <= w_held_d;
      aw_idx_q  <= aw_idx_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign s00_axi_awready = awready_q;
  assign s00_axi_wready  = wready_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_bresp   = bresp_q;
  assign s00_axi_arready = arready_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_rresp   = rresp_q;
  assign reg_wr_pulse    = pulse_q;

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DW +: DW] = regs_q[i];
  end

endmodule

// File: tb/tb_cls_axil_reg_slave.sv
// tb/tb_cls_axil_reg_slave.sv - scoreboard bench for cls_axil_reg_slave

module tb_cls_axil_reg_slave;

`ifdef CLS_AXIL_ERR_RESP_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0;
  logic        bready = 1'b1, rready = 1'b1;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata;
  logic [127:0] regs;
  logic [3:0]  pulse;

  int checks = 0;
  int failures = 0;
  logic [1:0]  bq[$];
  logic [33:0] rq[$];
  int pcnt[4];

  always #5 clk = ~clk;

  cls_axil_reg_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(5),
    .NUM_REGS(4)
  ) dut (
    .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(3'b000),
    .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb),
    .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(3'b000),
    .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp),
    .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg_q(regs), .reg_wr_pulse(pulse)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: pops scoreboard entries as responses complete; counts pulses.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bvalid && bready) begin
        if (bq.size() == 0) chk("b_unexpected", 1, 0);
        else chk("bresp", {126'b0, bresp}, {126'b0, bq.pop_front()});
      end
      if (rvalid && rready) begin
        if (rq.size() == 0) chk("r_unexpected", 1, 0);
        else chk("rdata_rresp", {94'b0, rdata, rresp}, {94'b0, rq.pop_front()});
      end
      for (int i = 0; i < 4; i++) if (pulse[i]) pcnt[i]++;
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic axi_write(input logic [4:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [1:0] er);
    bit aw_done, w_done, ah, wh;
    int t;
    bq.push_back(er);
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1'b1; wvalid = 1'b1;
    aw_done = 0; w_done = 0; t = 0;
    while (!(aw_done && w_done) && t < 50) begin
      ah = awvalid && awready;
      wh = wvalid && wready;
      cyc();
      if (ah) begin awvalid = 1'b0; aw_done = 1; end
      if (wh) begin wvalid = 1'b0; w_done = 1; end
      t++;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!(aw_done && w_done)) chk("write_timeout", 1, 0);
  endtask

  task automatic axi_read(input logic [4:0] a, input logic [31:0] d, input logic [1:0] er);
    bit done, rh;
    int t;
    rq.push_back({d, er});
    araddr = a; arvalid = 1'b1;
    done = 0; t = 0;
    while (!done && t < 50) begin
      rh = arready;
      cyc();
      if (rh) begin arvalid = 1'b0; done = 1; end
      t++;
    end
    arvalid = 1'b0;
    if (!done) chk("read_timeout", 1, 0);
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((bq.size() != 0 || rq.size() != 0 || bvalid || rvalid) && t < 100) begin
      cyc();
      t++;
    end
    if (t >= 100) chk("drain_timeout", 1, 0);
    cyc(); cyc();
  endtask

  initial begin
    // Reset state
    #100;
    chk("rst_readies", {awready, wready, arready}, 3'b000);
    chk("rst_valids", {bvalid, rvalid}, 2'b00);
    chk("rst_resp_rdata", {bresp, rresp, rdata}, 36'h0);
    chk("rst_regs_pulse", {regs, pulse}, '0);
    #100 rst_n = 1'b1;
    cyc();
    chk("readies_after_release", {awready, wready, arready}, 3'b111);

    // Basic write/read-back
    axi_write(5'h00, 32'h1, 4'hF, 2'b00);
    axi_write(5'h04, 32'h2, 4'hF, 2'b00);
    axi_write(5'h08, 32'h3, 4'hF, 2'b00);
    axi_write(5'h0C, 32'h4, 4'hF, 2'b00);
    axi_read(5'h00, 32'h1, 2'b00);
    axi_read(5'h04, 32'h2, 2'b00);
    axi_read(5'h08, 32'h3, 2'b00);
    axi_read(5'h0C, 32'h4, 2'b00);
    drain();
    chk("reg_q_basic", regs, 128'h00000004_00000003_00000002_00000001);

    // W at cycle n, AW at n+3
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
    bq.push_back(2'b00);
    wdata = 32'h5; wstrb = 4'hF; wvalid = 1'b1;
    chk("wgap_wready_n", wready, 1'b1);
    cyc(); wvalid = 1'b0;
    chk("wgap_wready_n1", wready, 1'b0);
    cyc();
    chk("wgap_wready_n2", {wready, bvalid}, 2'b00);
    cyc();
    chk("wgap_wready_n3", {wready, bvalid}, 2'b00);
    awaddr = 5'h00; awvalid = 1'b1;
    cyc(); awvalid = 1'b0;
    chk("wgap_n4_bvalid_wready", {bvalid, wready}, 2'b10);
    chk("wgap_n4_reg0", regs[31:0], 32'h5);
    chk("wgap_n4_pulse", pulse, 4'b0001);
    cyc();
    chk("wgap_n5", {wready, bvalid, pulse}, 6'b100000);
    drain();

    // Byte strobes and pulse counting
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
    axi_write(5'h04, 32'hAABBCCDD, 4'hF, 2'b00);
    axi_write(5'h04, 32'h11223344, 4'b0101, 2'b00);
    drain();
    chk("pulse1_two_writes", pcnt[1], 2);
    axi_write(5'h04, 32'hFFFFFFFF, 4'b0000, 2'b00);
    axi_read(5'h04, 32'hAA22CC44, 2'b00);
    drain();
    chk("pulse1_zero_strb", pcnt[1], 3);
    chk("pulse_others", pcnt[0] + pcnt[2] + pcnt[3], 0);

    // Read backpressure: rready low 5 cycles, second AR waits
    rready = 1'b0;
    rq.push_back({32'h3, 2'b00});
    rq.push_back({32'h4, 2'b00});
    araddr = 5'h08; arvalid = 1'b1;
    chk("bp_arready_first", arready, 1'b1);
    cyc();
    araddr = 5'h0C;
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold", {rvalid, arready, rdata}, {1'b1, 1'b0, 32'h3});
      cyc();
    end
    rready = 1'b1;
    chk("bp_arready_at_rready", arready, 1'b0);
    cyc();
    chk("bp_after_rready", {arready, rvalid}, 2'b10);
    cyc();
    arvalid = 1'b0;
    chk("bp_second_rvalid", {rvalid, rdata}, {1'b1, 32'h4});
    drain();

    // Same-edge read and write to reg 0 (currently 0x5)
    bq.push_back(2'b00);
    rq.push_back({32'h5, 2'b00});
    araddr = 5'h00; arvalid = 1'b1;
    awaddr = 5'h00; awvalid = 1'b1;
    wdata = 32'h9; wstrb = 4'hF; wvalid = 1'b1;
    chk("same_edge_readies", {awready, wready, arready}, 3'b111);
    cyc();
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
    drain();
    axi_read(5'h00, 32'h9, 2'b00);
    drain();

    // Out-of-range and unaligned accesses
    for (int i = 0; i < 4; i++) pcnt[i] = 0;
    axi_write(5'h10, 32'hDEADBEEF, 4'hF, OOR);
    axi_read(5'h10, 32'h0, OOR);
    axi_read(5'h1F, 32'h0, OOR);
    drain();
    chk("oor_reg_q", regs, 128'h00000004_00000003_AA22CC44_00000009);
    chk("oor_no_pulse", pcnt[0] + pcnt[1] + pcnt[2] + pcnt[3], 0);
    axi_read(5'h07, 32'hAA22CC44, 2'b00);
    axi_write(5'h0E, 32'h44, 4'hF, 2'b00);
    axi_read(5'h0C, 32'h44, 2'b00);
    drain();

    // Reset while a B response is pending
    bready = 1'b0;
    awaddr = 5'h0C; wdata = 32'h7; wstrb = 4'hF;
    awvalid = 1'b1; wvalid = 1'b1;
    cyc();
    awvalid = 1'b0; wvalid = 1'b0;
    chk("rstmid_bvalid_pending", bvalid, 1'b1);
    #3 rst_n = 1'b0;
    #1;
    chk("rstmid_bvalid_drop", {bvalid, awready, wready}, 3'b000);
    chk("rstmid_regs", regs, '0);
    repeat (3) cyc();
    #2 rst_n = 1'b1;
    bready = 1'b1;
    repeat (10) cyc();
    chk("rstmid_readies_back", {awready, wready, arready, bvalid}, 4'b1110);

    chk("bq_empty", bq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cls_axil_reg_slave.md
Name: cls_axil_reg_slave

Overview:
- AXI4-Lite responder: register bank for the cross-layer switch; the slave end of the S00_AXI control interface the verification master drives.
- Holds NUM_REGS 32-bit control words, exported flat to switch datapath with per-register write strobes.
- Handles AW/W arriving independently, byte strobes, and BVALID/RVALID holding under backpressure.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data width; only 32 supported
C_S_AXI_ADDR_WIDTH, 4, byte address width; decode uses bits [ADDR_WIDTH-1:2]
NUM_REGS, 4, implemented registers (≤ 2^(ADDR_WIDTH-2)); index ≥ NUM_REGS is out-of-range

Ports:
s00_axi_aclk  in  1  clock
s00_axi_aresetn  in  1  asynchronous active-low reset
s00_axi_awaddr  in  ADDR_WIDTH  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid / s00_axi_awready  in/out  1  AW handshake
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte enables
s00_axi_wvalid / s00_axi_wready  in/out  1  W handshake
s00_axi_bresp  out  2  write response
s00_axi_bvalid / s00_axi_bready  out/in  1  B handshake
s00_axi_araddr  in  ADDR_WIDTH  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid / s00_axi_arready  in/out  1  AR handshake
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  read response
s00_axi_rvalid / s00_axi_rready  out/in  1  R handshake
reg_q  out  NUM_REGS*32  register contents, reg i at [32i+31:32i]
reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after reg i updates

Behaviour:
- Reset (async assert, sync release): all readies, bvalid, rvalid, reg_wr_pulse = 0; bresp/rresp = 00; rdata = 0; reg_q = 0; AW/W held flags cleared. Mid-transaction reset aborts silently; no response issued afterwards.
- Readies are registered: first go high on first clock edge after aresetn deasserts.
- Write path, flags aw_held/w_held:
  - awready = !aw_held && !bvalid; wready = !w_held && !bvalid.
  - Handshake on AW latches addr and sets aw_held; on W latches data/strb and sets w_held.
  - Commit edge: first edge where AW and W are each either held or handshaking. At that edge: apply wstrb byte-wise to addressed reg, set bvalid, clear both flags.
  - AW and W in same cycle -> bvalid next cycle, reg_q updated same edge. W before AW (or reverse) allowed, any gap.
  - bvalid held with bresp stable until bready; readies low meanwhile. Max one write per 2 cycles.
  - wstrb = 0000: no bytes change, OKAY response, reg_wr_pulse still fires.
- Read path:
  - arready = !rvalid. On AR handshake: rdata/rresp latched, rvalid set next edge; held stable until rready.
  - Max one read per 2 cycles.
- Simultaneous read handshake and write commit to same reg: rdata returns pre-write value.
- Read and write channels fully independent; no priority stalls.
- Address low bits [1:0] ignored (unaligned treated as aligned).
- reg_wr_pulse[i] = 1 for exactly one cycle following commit to reg i.

Optional Feature:
CLS_AXIL_ERR_RESP_EN
- Defined: out-of-range write -> no register change, no pulse, bresp = 10 (SLVERR); out-of-range read -> rdata = 0, rresp = 10.
- Undefined: out-of-range write dropped with bresp = 00; read returns 0 with rresp = 00. In-range behaviour identical either way.

Test Plan:
- Release reset at 200 ns; write 0x1,0x2,0x3,0x4 to 0x0,0x4,0x8,0xC; read back each -> rdata matches, all resp 00, reg_q = 0x00000004_00000003_00000002_00000001.
- W at cycle n, AW at n+3, bready high -> bvalid at n+4; reg updated; wready low during n+1..n+4.
- Write 0xAABBCCDD to 0x4, then 0x11223344 with wstrb 0101 -> read 0x4 = 0xAA22CC44; reg_wr_pulse[1] pulses once per write.
- Read 0x8 with rready low 5 cycles -> rvalid/rdata stable 5 cycles, arready low; a second ARVALID is not accepted until the cycle after rready.
- Same-edge read of 0x0 (old 0x5) and write 0x9 to 0x0 -> rdata 0x5; next read 0x9.
- Macro on: write/read 0x10 with ADDR_WIDTH=5 -> bresp/rresp 10, rdata 0, reg_q unchanged; macro off -> 00. Reset asserted with bvalid pending -> bvalid drops immediately, no B after release.
